// File: rtl/t02_writeback_arbiter.sv
// Writeback arbiter: merges ALU results and in-order load returns onto a
// single register-file write port. A scoreboard tracks registers with a load
// in flight. A one-entry hold buffer catches an ALU result that loses the port
// to a load return.
// Optional feature: define T02_WB_BYPASS_EN to forward the write port onto the
// operand read outputs.
module t02_writeback_arbiter #(
  parameter int LDQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        ld_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        reg_write,
  output logic [4:0]  write_index,
  output logic [31:0] write_data,
  output logic        err
);

  localparam int PW = $clog2(LDQ_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(LDQ_DEPTH);

  logic [4:0]    tag_q [LDQ_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   sb;
  logic [31:0]   sb_next;
  logic          hold_valid;
  logic [4:0]    hold_rd;
  logic [31:0]   hold_data;

  logic          full;
  logic          empty;
  logic [4:0]    head;
  logic          ld_acc;
  logic          alu_acc;
  logic          ret;
  logic          sel;
  logic [4:0]    sel_idx;
  logic [31:0]   sel_data;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign head      = tag_q[rd_ptr];
  assign ld_ready  = !full && ((ld_rd == 5'd0) || !sb[ld_rd]);
  assign alu_ready = !hold_valid && !sb[alu_rd];
  assign ld_acc    = ld_issue && ld_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign ret       = mem_rvalid && !empty;

  // Write-port selection: load return, then hold entry, then direct ALU write.
  always_comb begin
    sel      = 1'b0;
    sel_idx  = '0;
    sel_data = '0;
    if (ret) begin
      sel      = 1'b1;
      sel_idx  = head;
      sel_data = mem_rdata;
    end else if (hold_valid) begin
      sel      = 1'b1;
      sel_idx  = hold_rd;
      sel_data = hold_data;
    end else if (alu_acc) begin
      sel      = 1'b1;
      sel_idx  = alu_rd;
      sel_data = alu_data;
    end
    // x0 writes are consumed but never reach the register file.
    reg_write   = nRST && sel && (sel_idx != 5'd0);
    write_index = reg_write ? sel_idx : 5'd0;
    write_data  = reg_write ? sel_data : 32'd0;
  end

  // Operand outputs, optionally forwarding the write in progress.
  always_comb begin
`ifdef T02_WB_BYPASS_EN
    rs1_data = rf_rdata1;
    rs2_data = rf_rdata2;
    rs1_busy = sb[rs1];
    rs2_busy = sb[rs2];
    if (reg_write && (write_index == rs1)) begin
      rs1_data = write_data;
      rs1_busy = 1'b0;
    end
    if (reg_write && (write_index == rs2)) begin
      rs2_data = write_data;
      rs2_busy = 1'b0;
    end
`else
    rs1_data = rf_rdata1;
    rs2_data = rf_rdata2;
    rs1_busy = sb[rs1];
    rs2_busy = sb[rs2];
`endif
  end

  // Scoreboard next value: the return clears first, so a same-rd issue wins.
  always_comb begin
    sb_next = sb;
    if (ret) sb_next[head] = 1'b0;
    if (ld_acc && (ld_rd != 5'd0)) sb_next[ld_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Load tag storage; contents are only meaningful under the valid count.
  always_ff @(posedge clk) begin
    if (ld_acc) tag_q[wr_ptr] <= ld_rd;
  end

  // Queue pointers, occupancy, scoreboard, hold entry and sticky error.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      sb         <= '0;
      hold_valid <= 1'b0;
      hold_rd    <= '0;
      hold_data  <= '0;
      err        <= 1'b0;
    end else begin
      if (ld_acc) wr_ptr <= wr_ptr + PW'(1);
      if (ret)    rd_ptr <= rd_ptr + PW'(1);
      case ({ld_acc, ret})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      sb <= sb_next;
      if (alu_acc && ret) begin
        hold_valid <= 1'b1;
        hold_rd    <= alu_rd;
        hold_data  <= alu_data;
      end else if (hold_valid && !ret) begin
        hold_valid <= 1'b0;
      end
      if (mem_rvalid && empty) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t02_writeback_arbiter.sv
module tb_t02_writeback_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        nRST;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1, rs2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rs1_busy, rs2_busy;
  logic [31:0] rs1_data, rs2_data;
  logic        reg_write;
  logic [4:0]  write_index;
  logic [31:0] write_data;
  logic        err;

  t02_writeback_arbiter #(.LDQ_DEPTH(DEPTH)) dut (
    .clk(clk), .nRST(nRST),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_ready(ld_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rs1(rs1), .rs2(rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .reg_write(reg_write), .write_index(write_index), .write_data(write_data), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tag queue, busy set, hold slot, sticky error.
  logic [4:0]  mq [$];
  logic [31:0] msb;
  logic        mhv;
  logic [4:0]  mhrd;
  logic [31:0] mhdata;
  logic        merr;

  task automatic model_reset();
    mq.delete();
    msb = '0;
    mhv = 1'b0;
    mhrd = '0;
    mhdata = '0;
    merr = 1'b0;
  endtask

  task automatic model_step();
    logic        e_ldr, e_alur, rtn, sel, e_rw, alu_acc, ld_acc;
    logic [4:0]  idx, popped;
    logic [31:0] dat;
    logic [31:0] e_d1, e_d2;
    logic        e_b1, e_b2;
    e_ldr  = (mq.size() < DEPTH) && (ld_rd == 0 || !msb[ld_rd]);
    e_alur = !mhv && !msb[alu_rd];
    rtn    = mem_rvalid && (mq.size() != 0);
    sel = 1'b0; idx = '0; dat = '0;
    if (rtn) begin sel = 1'b1; idx = mq[0]; dat = mem_rdata; end
    else if (mhv) begin sel = 1'b1; idx = mhrd; dat = mhdata; end
    else if (alu_valid && e_alur) begin sel = 1'b1; idx = alu_rd; dat = alu_data; end
    e_rw = sel && (idx != 0);
    e_d1 = rf_rdata1; e_d2 = rf_rdata2;
    e_b1 = msb[rs1];  e_b2 = msb[rs2];
`ifdef T02_WB_BYPASS_EN
    if (e_rw && idx == rs1) begin e_d1 = dat; e_b1 = 1'b0; end
    if (e_rw && idx == rs2) begin e_d2 = dat; e_b2 = 1'b0; end
`endif
    chk("m_alu_ready", alu_ready, e_alur);
    chk("m_ld_ready", ld_ready, e_ldr);
    chk("m_reg_write", reg_write, e_rw);
    if (e_rw || !sel) begin
      chk("m_write_index", write_index, e_rw ? idx : 5'd0);
      chk("m_write_data", write_data, e_rw ? dat : 32'd0);
    end
    chk("m_err", err, merr);
    chk("m_rs1_busy", rs1_busy, e_b1);
    chk("m_rs2_busy", rs2_busy, e_b2);
    chk("m_rs1_data", rs1_data, e_d1);
    chk("m_rs2_data", rs2_data, e_d2);
    alu_acc = alu_valid && e_alur;
    ld_acc  = ld_issue && e_ldr;
    if (mem_rvalid && mq.size() == 0) merr = 1'b1;
    if (rtn) begin popped = mq.pop_front(); msb[popped] = 1'b0; end
    if (ld_acc) begin mq.push_back(ld_rd); if (ld_rd != 0) msb[ld_rd] = 1'b1; end
    if (alu_acc && rtn) begin mhv = 1'b1; mhrd = alu_rd; mhdata = alu_data; end
    else if (mhv && !rtn) mhv = 1'b0;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_rd = 0; mem_rvalid = 0; mem_rdata = 0;
    rs1 = 0; rs2 = 0; rf_rdata1 = 32'h0000_1111; rf_rdata2 = 32'h0000_2222;
  endtask

  // Inputs are set by the caller at posedge+1; outputs checked at negedge.
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        av; logic [4:0] ard; logic [31:0] adata;
    logic        li; logic [4:0] lrd;
    logic        mv; logic [31:0] mdata;
    logic [4:0]  r1;
    logic        e_rw; logic [4:0] e_idx; logic [31:0] e_data;
    logic        e_ar; logic e_lr; logic e_b1;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'hA5,   1'b0, 5'd0, 1'b0, 32'h0,    5'd0, 1'b1, 5'd5, 32'hA5,   1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 1'b0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 5'd7, 32'h77,   1'b0, 5'd0, 1'b0, 32'h0,    5'd7, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 5'd7, 32'h77,   1'b0, 5'd0, 1'b1, 32'h1234, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 5'd7, 32'h77,   1'b0, 5'd0, 1'b0, 32'h0,    5'd0, 1'b1, 5'd7, 32'h77,   1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 1'b0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 5'd3, 32'h33,   1'b0, 5'd0, 1'b1, 32'h9999, 5'd0, 1'b1, 5'd9, 32'h9999, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 5'd4, 32'h44,   1'b0, 5'd0, 1'b0, 32'h0,    5'd0, 1'b1, 5'd3, 32'h33,   1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 5'd4, 32'h44,   1'b0, 5'd0, 1'b0, 32'h0,    5'd0, 1'b1, 5'd4, 32'h44,   1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 1'b0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 5'd0, 32'hFF,   1'b0, 5'd0, 1'b0, 32'h0,    5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b0};

    // Reset: outputs forced even with an ALU offer present.
    idle();
    nRST = 1'b0;
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'hDEAD;
    #2;
    chk("rst_reg_write", reg_write, 1'b0);
    chk("rst_alu_ready", alu_ready, 1'b1);
    chk("rst_ld_ready", ld_ready, 1'b1);
    chk("rst_err", err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    nRST = 1'b1;
    idle();
    model_reset();

    // Directed table: basic write, WAW stall, return-vs-ALU collision, x0 drop.
    for (int i = 0; i < 11; i++) begin
      idle();
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adata;
      ld_issue = tbl[i].li; ld_rd = tbl[i].lrd;
      mem_rvalid = tbl[i].mv; mem_rdata = tbl[i].mdata;
      rs1 = tbl[i].r1;
      @(negedge clk);
      chk($sformatf("t%0d_reg_write", i), reg_write, tbl[i].e_rw);
      if (tbl[i].e_rw || (!tbl[i].av && !tbl[i].mv)) begin
        chk($sformatf("t%0d_write_index", i), write_index, tbl[i].e_idx);
        chk($sformatf("t%0d_write_data", i), write_data, tbl[i].e_data);
      end
      chk($sformatf("t%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("t%0d_ld_ready", i), ld_ready, tbl[i].e_lr);
      chk($sformatf("t%0d_rs1_busy", i), rs1_busy, tbl[i].e_b1);
      model_step();
      @(posedge clk);
      #1;
    end

    // Fill the queue, refuse a fifth issue even alongside a return, drain in order.
    for (int i = 1; i <= 4; i++) begin
      idle(); ld_issue = 1; ld_rd = 5'(i);
      #1 chk("fill_ld_ready", ld_ready, 1'b1);
      cycle();
    end
    idle(); ld_issue = 1; ld_rd = 5'd5;
    #1 chk("full_ld_ready", ld_ready, 1'b0);
    cycle();
    idle(); ld_issue = 1; ld_rd = 5'd5; mem_rvalid = 1; mem_rdata = 32'h101;
    #1 chk("full_ret_ld_ready", ld_ready, 1'b0);
    chk("drain_idx1", write_index, 5'd1);
    cycle();
    for (int i = 2; i <= 4; i++) begin
      idle(); mem_rvalid = 1; mem_rdata = 32'h100 + 32'(i);
      #1 chk("drain_idx", write_index, 5'(i));
      chk("drain_data", write_data, 32'h100 + 32'(i));
      cycle();
    end

    // Return with nothing pending, then reset with a load in flight.
    idle(); mem_rvalid = 1; mem_rdata = 32'h55;
    #1 chk("orphan_reg_write", reg_write, 1'b0);
    cycle();
    idle();
    #1 chk("orphan_err", err, 1'b1);
    cycle();
    idle(); ld_issue = 1; ld_rd = 5'd6;
    cycle();
    idle(); rs1 = 5'd6;
    #1 chk("inflight_busy", rs1_busy, 1'b1);
    nRST = 1'b0;
    #1;
    chk("midrst_err", err, 1'b0);
    chk("midrst_busy", rs1_busy, 1'b0);
    @(posedge clk);
    #1;
    nRST = 1'b1;
    model_reset();
    idle(); rs1 = 5'd6;
    cycle();
    idle(); mem_rvalid = 1; mem_rdata = 32'h66;
    #1 chk("stale_ret_reg_write", reg_write, 1'b0);
    cycle();
    idle();
    #1 chk("stale_ret_err", err, 1'b1);
    cycle();

    // Operand read during a return to the same register.
    idle(); ld_issue = 1; ld_rd = 5'd9;
    cycle();
    idle(); mem_rvalid = 1; mem_rdata = 32'hBEEF; rs1 = 5'd9; rf_rdata1 = 32'h1111;
    #1;
`ifdef T02_WB_BYPASS_EN
    chk("byp_rs1_data", rs1_data, 32'hBEEF);
    chk("byp_rs1_busy", rs1_busy, 1'b0);
`else
    chk("nobyp_rs1_data", rs1_data, 32'h1111);
    chk("nobyp_rs1_busy", rs1_busy, 1'b1);
`endif
    cycle();

    // Random traffic against the reference model; clean restart first.
    nRST = 1'b0;
    #1;
    nRST = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      alu_valid  = 1'($urandom_range(0, 1));
      alu_rd     = 5'($urandom_range(0, 7));
      alu_data   = $urandom;
      ld_issue   = 1'($urandom_range(0, 1));
      ld_rd      = 5'($urandom_range(0, 7));
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      if (mem_rvalid && mq.size() == 0) alu_valid = 1'b0;
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rf_rdata1 = $urandom;
      rf_rdata2 = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
